// File: rtl/refill_ctrl.sv
// Cache miss/refill controller: tag lookup, optional dirty-victim write-back
// burst, line refill burst into the data array, then tag update.
module refill_ctrl #(
  parameter int ATEG_WIDTH    = 7,
  parameter int AINDEX_WIDTH  = 6,
  parameter int CHANNEL_WIDTH = 3,
  parameter int OFFSET_WIDTH  = 2,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                                              clk_i,
  input  logic                                              reset_i,
  input  logic                                              cpu_req_i,
  input  logic                                              cpu_we_i,
  input  logic [ATEG_WIDTH+AINDEX_WIDTH+OFFSET_WIDTH-1:0]   cpu_addr_i,
  output logic                                              cpu_ready_o,
  output logic [CHANNEL_WIDTH-1:0]                          cpu_chan_o,
  output logic [ATEG_WIDTH+AINDEX_WIDTH-1:0]                tag_addr_o,
  output logic                                              tag_wr_o,
  output logic                                              tag_md_o,
  input  logic                                              tag_hit_i,
  input  logic [CHANNEL_WIDTH-1:0]                          tag_chan_i,
  input  logic [ATEG_WIDTH+1:0]                             tag_in_i,
  output logic                                              mem_req_o,
  output logic                                              mem_we_o,
  output logic [ATEG_WIDTH+AINDEX_WIDTH+OFFSET_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]                             mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]                             mem_rdata_i,
  input  logic                                              mem_ack_i,
  output logic [CHANNEL_WIDTH-1:0]                          dat_chan_o,
  output logic [OFFSET_WIDTH-1:0]                           dat_word_o,
  output logic                                              dat_we_o,
  output logic [DATA_WIDTH-1:0]                             dat_wdata_o,
  input  logic [DATA_WIDTH-1:0]                             dat_rdata_i
);

  localparam int AW  = ATEG_WIDTH + AINDEX_WIDTH + OFFSET_WIDTH;
  localparam int TAW = ATEG_WIDTH + AINDEX_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_UPDATE,
    S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [OFFSET_WIDTH-1:0]   beat_q, beat_d;
  logic [TAW-1:0]            req_ti_q, req_ti_d;
  logic                      req_we_q, req_we_d;
  logic [CHANNEL_WIDTH-1:0]  victim_q, victim_d;
  logic [ATEG_WIDTH-1:0]     vtag_q, vtag_d;

  logic [AINDEX_WIDTH-1:0]   req_idx;
  logic                      last_beat;
  logic                      victim_dirty;

  // Word offset of the CPU address is irrelevant to a whole-line refill.
  logic unused_offset_bits;
  assign unused_offset_bits = ^cpu_addr_i[OFFSET_WIDTH-1:0];

  assign req_idx      = req_ti_q[AINDEX_WIDTH-1:0];
  assign last_beat    = &beat_q;
  assign victim_dirty = tag_in_i[ATEG_WIDTH+1] & tag_in_i[ATEG_WIDTH];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      req_ti_q <= '0;
      req_we_q <= 1'b0;
      victim_q <= '0;
      vtag_q   <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      req_ti_q <= req_ti_d;
      req_we_q <= req_we_d;
      victim_q <= victim_d;
      vtag_q   <= vtag_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    req_ti_d    = req_ti_q;
    req_we_d    = req_we_q;
    victim_d    = victim_q;
    vtag_d      = vtag_q;

    cpu_ready_o = 1'b0;
    cpu_chan_o  = '0;
    tag_wr_o    = 1'b0;
    tag_md_o    = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    dat_chan_o  = '0;
    dat_word_o  = '0;
    dat_we_o    = 1'b0;
    dat_wdata_o = '0;

    // The lookup address is forced to zero while reset is held.
    if (reset_i) begin
      tag_addr_o = '0;
    end else if (state_q == S_IDLE) begin
      tag_addr_o = cpu_addr_i[AW-1:OFFSET_WIDTH];
    end else begin
      tag_addr_o = req_ti_q;
    end

    case (state_q)
      S_IDLE: begin
        if (cpu_req_i) begin
          req_ti_d = cpu_addr_i[AW-1:OFFSET_WIDTH];
          req_we_d = cpu_we_i;
          state_d  = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (tag_hit_i) begin
          cpu_ready_o = 1'b1;
          cpu_chan_o  = tag_chan_i;
          tag_wr_o    = req_we_q;
          tag_md_o    = req_we_q;
          state_d     = S_IDLE;
        end else begin
          victim_d = tag_chan_i;
          vtag_d   = tag_in_i[ATEG_WIDTH-1:0];
          beat_d   = '0;
          state_d  = victim_dirty ? S_WB : S_FILL;
        end
      end

      S_WB: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {vtag_q, req_idx, beat_q};
        mem_wdata_o = dat_rdata_i;
        dat_chan_o  = victim_q;
        dat_word_o  = beat_q;
        if (mem_ack_i) begin
          beat_d = beat_q + OFFSET_WIDTH'(1);
          if (last_beat) begin
            state_d = S_FILL;
          end
        end
      end

      S_FILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {req_ti_q, beat_q};
        dat_chan_o = victim_q;
        dat_word_o = beat_q;
        if (mem_ack_i) begin
          dat_we_o    = 1'b1;
          dat_wdata_o = mem_rdata_i;
          beat_d      = beat_q + OFFSET_WIDTH'(1);
          if (last_beat) begin
            state_d = S_UPDATE;
          end
        end
      end

      // Tag memory picks its FIFO way on this write, which is still victim_q.
      S_UPDATE: begin
        tag_wr_o = 1'b1;
        tag_md_o = req_we_q;
        state_d  = S_DONE;
      end

      S_DONE: begin
        cpu_ready_o = 1'b1;
        cpu_chan_o  = victim_q;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_refill_ctrl.sv
// Directed, table-driven bench for refill_ctrl: one row per clock cycle of
// stimulus plus expected outputs, and a hand-written mid-burst reset sequence.
module tb_refill_ctrl;

  localparam int AT  = 7;
  localparam int AI  = 6;
  localparam int CW  = 3;
  localparam int OW  = 2;
  localparam int DW  = 32;
  localparam int AW  = AT + AI + OW;
  localparam int TAW = AT + AI;
  localparam int TIW = AT + 2;

  logic           clk;
  logic           reset;
  logic           cpu_req;
  logic           cpu_we;
  logic [AW-1:0]  cpu_addr;
  logic           cpu_ready;
  logic [CW-1:0]  cpu_chan;
  logic [TAW-1:0] tag_addr;
  logic           tag_wr;
  logic           tag_md;
  logic           tag_hit;
  logic [CW-1:0]  tag_chan;
  logic [TIW-1:0] tag_in;
  logic           mem_req;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  mem_rdata;
  logic           mem_ack;
  logic [CW-1:0]  dat_chan;
  logic [OW-1:0]  dat_word;
  logic           dat_we;
  logic [DW-1:0]  dat_wdata;
  logic [DW-1:0]  dat_rdata;

  refill_ctrl #(
    .ATEG_WIDTH   (AT),
    .AINDEX_WIDTH (AI),
    .CHANNEL_WIDTH(CW),
    .OFFSET_WIDTH (OW),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .cpu_req_i  (cpu_req),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_ready_o(cpu_ready),
    .cpu_chan_o (cpu_chan),
    .tag_addr_o (tag_addr),
    .tag_wr_o   (tag_wr),
    .tag_md_o   (tag_md),
    .tag_hit_i  (tag_hit),
    .tag_chan_i (tag_chan),
    .tag_in_i   (tag_in),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .mem_ack_i  (mem_ack),
    .dat_chan_o (dat_chan),
    .dat_word_o (dat_word),
    .dat_we_o   (dat_we),
    .dat_wdata_o(dat_wdata),
    .dat_rdata_i(dat_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           req;
    logic           we;
    logic [AW-1:0]  addr;
    logic           hit;
    logic [CW-1:0]  tchan;
    logic [TIW-1:0] tin;
    logic           ack;
    logic [DW-1:0]  rdata;
    logic [DW-1:0]  drdata;
    logic           e_rdy;
    logic [CW-1:0]  e_cchan;
    logic [TAW-1:0] e_taddr;
    logic           e_twr;
    logic           e_tmd;
    logic           e_mreq;
    logic           e_mwe;
    logic [AW-1:0]  e_maddr;
    logic [DW-1:0]  e_mwdata;
    logic [CW-1:0]  e_dchan;
    logic [OW-1:0]  e_dword;
    logic           e_dwe;
    logic [DW-1:0]  e_dwdata;
    logic           c_cc;
    logic           c_md;
    logic           c_mem;
    logic           c_mwd;
    logic           c_dat;
    logic           c_dwd;
  } vec_t;

  vec_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [AW-1:0] JUNK_ADDR = 15'h7ABC;

  function automatic logic [AW-1:0] mk(input int t, input int i, input int o);
    logic [AT-1:0] tt;
    logic [AI-1:0] ii;
    logic [OW-1:0] oo;
    tt = t[AT-1:0];
    ii = i[AI-1:0];
    oo = o[OW-1:0];
    return {tt, ii, oo};
  endfunction

  function automatic vec_t blank();
    vec_t v;
    v = '{default: '0};
    // Outside IDLE the CPU drives garbage, which must be ignored.
    v.req    = 1'b1;
    v.we     = 1'b1;
    v.addr   = JUNK_ADDR;
    v.ack    = 1'b1;
    v.rdata  = 32'hDEAD_0000;
    v.drdata = 32'hBEEF_0000;
    return v;
  endfunction

  task automatic idle_none(input logic [AW-1:0] a);
    vec_t v;
    v = blank();
    v.req     = 1'b0;
    v.addr    = a;
    v.e_taddr = a[AW-1:OW];
    q.push_back(v);
  endtask

  task automatic idle_req(input logic we, input logic [AW-1:0] a);
    vec_t v;
    v = blank();
    v.we      = we;
    v.addr    = a;
    v.e_taddr = a[AW-1:OW];
    q.push_back(v);
  endtask

  task automatic lookup_hit(input logic [TAW-1:0] ta, input logic [CW-1:0] ch, input logic we);
    vec_t v;
    v = blank();
    v.hit     = 1'b1;
    v.tchan   = ch;
    v.tin     = {2'b11, 7'd9};
    v.e_taddr = ta;
    v.e_rdy   = 1'b1;
    v.c_cc    = 1'b1;
    v.e_cchan = ch;
    v.e_twr   = we;
    v.c_md    = we;
    v.e_tmd   = 1'b1;
    q.push_back(v);
  endtask

  task automatic lookup_miss(input logic [TAW-1:0] ta, input logic [CW-1:0] ch, input logic [TIW-1:0] tin);
    vec_t v;
    v = blank();
    v.hit     = 1'b0;
    v.tchan   = ch;
    v.tin     = tin;
    v.e_taddr = ta;
    q.push_back(v);
  endtask

  task automatic wb(input logic [TAW-1:0] ta, input logic ack, input logic [DW-1:0] drd,
                    input logic [AT-1:0] vtag, input int beat, input logic [CW-1:0] vic);
    vec_t v;
    logic [OW-1:0] b;
    b = beat[OW-1:0];
    v = blank();
    v.ack      = ack;
    v.drdata   = drd;
    v.e_taddr  = ta;
    v.e_mreq   = 1'b1;
    v.c_mem    = 1'b1;
    v.e_mwe    = 1'b1;
    v.e_maddr  = {vtag, ta[AI-1:0], b};
    v.c_mwd    = 1'b1;
    v.e_mwdata = drd;
    v.c_dat    = 1'b1;
    v.e_dchan  = vic;
    v.e_dword  = b;
    q.push_back(v);
  endtask

  task automatic fill(input logic [TAW-1:0] ta, input logic ack, input logic [DW-1:0] rd,
                      input int beat, input logic [CW-1:0] vic);
    vec_t v;
    logic [OW-1:0] b;
    b = beat[OW-1:0];
    v = blank();
    v.ack     = ack;
    v.rdata   = rd;
    v.e_taddr = ta;
    v.e_mreq  = 1'b1;
    v.c_mem   = 1'b1;
    v.e_mwe   = 1'b0;
    v.e_maddr = {ta, b};
    if (ack) begin
      v.c_dat    = 1'b1;
      v.e_dchan  = vic;
      v.e_dword  = b;
      v.e_dwe    = 1'b1;
      v.c_dwd    = 1'b1;
      v.e_dwdata = rd;
    end
    q.push_back(v);
  endtask

  task automatic update(input logic [TAW-1:0] ta, input logic md);
    vec_t v;
    v = blank();
    v.e_taddr = ta;
    v.e_twr   = 1'b1;
    v.c_md    = 1'b1;
    v.e_tmd   = md;
    q.push_back(v);
  endtask

  task automatic done(input logic [TAW-1:0] ta, input logic [CW-1:0] ch);
    vec_t v;
    v = blank();
    v.e_taddr = ta;
    v.e_rdy   = 1'b1;
    v.c_cc    = 1'b1;
    v.e_cchan = ch;
    q.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    logic [105:0] all_out;
    all_out = {cpu_ready, cpu_chan, tag_addr, tag_wr, tag_md, mem_req, mem_we, mem_addr,
               mem_wdata, dat_chan, dat_word, dat_we, dat_wdata};
    n_cmp++;
    if (all_out !== '0) begin
      n_err++;
      $display("FAIL %s: outputs %h expected all zero", name, all_out);
    end else begin
      $display("%s: all outputs zero", name);
    end
  endtask

  task automatic run_table();
    vec_t v;
    for (int i = 0; i < q.size(); i++) begin
      v = q[i];
      @(posedge clk);
      #1;
      cpu_req   = v.req;
      cpu_we    = v.we;
      cpu_addr  = v.addr;
      tag_hit   = v.hit;
      tag_chan  = v.tchan;
      tag_in    = v.tin;
      mem_ack   = v.ack;
      mem_rdata = v.rdata;
      dat_rdata = v.drdata;
      @(negedge clk);
      chk("cpu_ready", i, 32'(cpu_ready), 32'(v.e_rdy));
      chk("tag_addr",  i, 32'(tag_addr),  32'(v.e_taddr));
      chk("tag_wr",    i, 32'(tag_wr),    32'(v.e_twr));
      chk("mem_req",   i, 32'(mem_req),   32'(v.e_mreq));
      chk("dat_we",    i, 32'(dat_we),    32'(v.e_dwe));
      if (v.c_cc)  chk("cpu_chan",  i, 32'(cpu_chan),  32'(v.e_cchan));
      if (v.c_md)  chk("tag_md",    i, 32'(tag_md),    32'(v.e_tmd));
      if (v.c_mem) chk("mem_we",    i, 32'(mem_we),    32'(v.e_mwe));
      if (v.c_mem) chk("mem_addr",  i, 32'(mem_addr),  32'(v.e_maddr));
      if (v.c_mwd) chk("mem_wdata", i, mem_wdata,      v.e_mwdata);
      if (v.c_dat) chk("dat_chan",  i, 32'(dat_chan),  32'(v.e_dchan));
      if (v.c_dat) chk("dat_word",  i, 32'(dat_word),  32'(v.e_dword));
      if (v.c_dwd) chk("dat_wdata", i, dat_wdata,      v.e_dwdata);
      $display("row %0d: req=%b ack=%b rdy=%b twr=%b mreq=%b mwe=%b maddr=%h dwe=%b",
               i, v.req, v.ack, cpu_ready, tag_wr, mem_req, mem_we, mem_addr, dat_we);
    end
    q.delete();
  endtask

  task automatic drive_quiet();
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    tag_hit   = 1'b0;
    tag_chan  = '0;
    tag_in    = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    dat_rdata = '0;
  endtask

  logic [AW-1:0]  a_addr, b_addr, c_addr, d_addr;
  logic [TAW-1:0] ta, tb, tc, td;

  initial begin
    reset     = 1'b1;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = JUNK_ADDR;
    tag_hit   = 1'b1;
    tag_chan  = 3'd7;
    tag_in    = '1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hA5A5_A5A5;
    dat_rdata = 32'h5A5A_5A5A;
    repeat (2) @(negedge clk);
    chk_zero("reset_outs");
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_quiet();

    a_addr = mk(5, 3, 1);   ta = a_addr[AW-1:OW];
    b_addr = mk(12, 3, 0);  tb = b_addr[AW-1:OW];
    c_addr = mk(20, 7, 2);  tc = c_addr[AW-1:OW];
    d_addr = mk(33, 10, 3); td = d_addr[AW-1:OW];

    // Clean miss into an empty way
    idle_none(mk(1, 2, 3));
    idle_req(1'b0, a_addr);
    lookup_miss(ta, 3'd2, {2'b00, 7'd0});
    for (int b = 0; b < 4; b++) fill(ta, 1'b1, 32'h1000_0000 + 32'(b), b, 3'd2);
    update(ta, 1'b0);
    done(ta, 3'd2);
    // Load hit, then store hit accepted the cycle after ready
    idle_req(1'b0, a_addr);
    lookup_hit(ta, 3'd2, 1'b0);
    idle_req(1'b1, a_addr);
    lookup_hit(ta, 3'd2, 1'b1);
    // Dirty victim: write-back burst (one stalled beat) then refill, store miss
    idle_req(1'b1, b_addr);
    lookup_miss(tb, 3'd5, {2'b11, 7'd9});
    wb(tb, 1'b1, 32'hB000_0000, 7'd9, 0, 3'd5);
    wb(tb, 1'b0, 32'hB000_0011, 7'd9, 1, 3'd5);
    wb(tb, 1'b1, 32'hB000_0001, 7'd9, 1, 3'd5);
    wb(tb, 1'b1, 32'hB000_0002, 7'd9, 2, 3'd5);
    wb(tb, 1'b1, 32'hB000_0003, 7'd9, 3, 3'd5);
    for (int b = 0; b < 4; b++) fill(tb, 1'b1, 32'hC000_0000 + 32'(b), b, 3'd5);
    update(tb, 1'b1);
    done(tb, 3'd5);
    // Valid but clean victim goes straight to FILL; ack withheld 5 cycles at beat 2
    idle_req(1'b0, c_addr);
    lookup_miss(tc, 3'd1, {2'b10, 7'd3});
    fill(tc, 1'b1, 32'hD000_0000, 0, 3'd1);
    fill(tc, 1'b1, 32'hD000_0001, 1, 3'd1);
    for (int k = 0; k < 5; k++) fill(tc, 1'b0, 32'hEEEE_0000 + 32'(k), 2, 3'd1);
    fill(tc, 1'b1, 32'hD000_0002, 2, 3'd1);
    fill(tc, 1'b1, 32'hD000_0003, 3, 3'd1);
    update(tc, 1'b0);
    done(tc, 3'd1);
    idle_none(mk(0, 0, 0));
    run_table();

    // Reset asserted asynchronously during write-back beat 2
    idle_req(1'b0, d_addr);
    lookup_miss(td, 3'd4, {2'b11, 7'd17});
    wb(td, 1'b1, 32'h0000_0100, 7'd17, 0, 3'd4);
    wb(td, 1'b1, 32'h0000_0101, 7'd17, 1, 3'd4);
    run_table();
    @(posedge clk);
    #1;
    cpu_req   = 1'b1;
    cpu_addr  = JUNK_ADDR;
    mem_ack   = 1'b0;
    mem_rdata = 32'h1234_5678;
    dat_rdata = 32'h8765_4321;
    #2;
    chk("pre_rst_maddr", 0, 32'(mem_addr), 32'({7'd17, 6'd10, 2'd2}));
    chk("pre_rst_mreq",  0, 32'(mem_req),  32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk_zero("async_reset_outs");
    @(posedge clk);
    #1;
    chk_zero("held_reset_outs");
    reset = 1'b0;
    drive_quiet();

    // Fresh request after reset must start at LOOKUP, then refill from beat 0
    idle_req(1'b0, d_addr);
    lookup_miss(td, 3'd4, {2'b00, 7'd0});
    for (int b = 0; b < 4; b++) fill(td, 1'b1, 32'hF000_0000 + 32'(b), b, 3'd4);
    update(td, 1'b0);
    done(td, 3'd4);
    run_table();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/refill_ctrl.md
Name: refill_ctrl

Overview:
- Cache miss/refill controller. Drives the tag memory lookup and update interface (addr, wr, md), and consumes its hit, chan and tegOut results.
- Sequences victim write-back and line refill bursts to the next memory level. Writes refilled words into the data array.
- Sits between the CPU request port, the tag memory and the external memory bus.

Parameters:
- ATEG_WIDTH, 7, tag field width
- AINDEX_WIDTH, 6, set index width
- CHANNEL_WIDTH, 3, log2 of number of ways
- OFFSET_WIDTH, 2, log2 of words per line (4 beats per burst)
- DATA_WIDTH, 32, word width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  access request, sampled only in IDLE
- cpu_we  in  1  1 = store, 0 = load; sampled with cpu_req
- cpu_addr  in  ATEG_WIDTH+AINDEX_WIDTH+OFFSET_WIDTH  {tag,index,offset}
- cpu_ready  out  1  one-cycle pulse: access may complete
- cpu_chan  out  CHANNEL_WIDTH  way holding the line; valid while cpu_ready=1
- tag_addr  out  ATEG_WIDTH+AINDEX_WIDTH  {tag,index} to tag memory
- tag_wr  out  1  tag memory write strobe
- tag_md  out  1  modified bit written with tag_wr
- tag_hit  in  1  tag memory hit
- tag_chan  in  CHANNEL_WIDTH  hit way, or FIFO victim on miss
- tag_in  in  ATEG_WIDTH+2  {valid, modified, tag[ATEG_WIDTH-1:0]} of tag_chan
- mem_req  out  1  burst active
- mem_we  out  1  1 = write-back burst, 0 = refill burst
- mem_addr  out  ATEG_WIDTH+AINDEX_WIDTH+OFFSET_WIDTH  word address of current beat
- mem_wdata  out  DATA_WIDTH  write-back word (from dat_rdata)
- mem_rdata  in  DATA_WIDTH  refill word
- mem_ack  in  1  one-cycle beat acknowledge
- dat_chan  out  CHANNEL_WIDTH  data array way select
- dat_word  out  OFFSET_WIDTH  data array word select
- dat_we  out  1  data array write strobe
- dat_wdata  out  DATA_WIDTH  data array write word (= mem_rdata)
- dat_rdata  in  DATA_WIDTH  data array read word at dat_chan/dat_word, combinational

Behaviour:
- Reset (asynchronous, any state): state=IDLE, beat counter=0, all latches cleared. All outputs 0.
- Latched in IDLE on cpu_req: req_addr, req_we.
- tag_addr = req_addr[tag,index] in every state except IDLE, where it is cpu_addr[tag,index].
- The tag memory is combinational; its results are used in the LOOKUP cycle.
- IDLE: on cpu_req=1 latch request, go to LOOKUP. Otherwise stay.
- LOOKUP (1 cycle):
  - Hit: cpu_ready=1 and cpu_chan=tag_chan this cycle. If req_we=1, also tag_wr=1 with tag_md=1. Next state IDLE.
  - Miss: latch victim=tag_chan and vtag=tag_in[ATEG_WIDTH-1:0].
  - Miss with tag_in valid and modified both 1: go to WB. Otherwise go to FILL. Beat counter=0.
- WB:
  - mem_req=1, mem_we=1, mem_addr={vtag, index, beat}.
  - dat_chan=victim, dat_word=beat, mem_wdata=dat_rdata.
  - On mem_ack, beat+1. On the ack of beat 2**OFFSET_WIDTH-1, beat wraps to 0 and state goes to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr={req tag, index, beat}.
  - On mem_ack: dat_we=1, dat_chan=victim, dat_word=beat, dat_wdata=mem_rdata, beat+1.
  - On the last beat's ack, go to UPDATE.
- UPDATE (1 cycle): tag_wr=1, tag_md=req_we. The tag memory miss path writes the FIFO way, which equals victim because no other tag write occurs during the miss. Go to DONE.
- DONE (1 cycle): cpu_ready=1, cpu_chan=victim. Go to IDLE.
- Latency:
  - Hit: ready 1 cycle after the request cycle.
  - Clean miss: 2**OFFSET_WIDTH acks + 3 cycles.
  - Dirty miss adds 2**OFFSET_WIDTH acks.
- mem_req is continuous across back-to-back WB→FILL. It drops in UPDATE.
- mem_ack outside WB/FILL is ignored.
- cpu_req outside IDLE is ignored. The CPU holds no signals after the request cycle.
- A new request is accepted in IDLE in the cycle after cpu_ready.
- Beat counter is OFFSET_WIDTH bits and wraps naturally; no other arithmetic.

Test Plan:
- Reset, load addr tag=5/idx=3 to empty cache → miss, no WB, 4 FILL beats at mem_addr {5,3,0..3}, dat_we ×4 with dat_word 0..3. UPDATE tag_wr=1 tag_md=0, then cpu_ready.
- Repeat same load → hit: cpu_ready in next cycle, cpu_chan=filled way, no mem_req, tag_wr=0.
- Store hit to same line → tag_wr=1, tag_md=1, cpu_ready in the LOOKUP cycle.
- Miss whose victim has tag_in={1,1,tag 9} → 4 WB beats mem_we=1 at {9,idx,0..3} with mem_wdata=dat_rdata, then 4 FILL beats with no mem_req gap.
- mem_ack held low 5 cycles mid-FILL → beat and mem_addr frozen, no dat_we until ack.
- Assert reset during WB beat 2 → all outputs 0 immediately. Next request restarts from LOOKUP with beat 0.
